// File: rtl/thermo_seq.sv
// Thermometer-code step sequencer: a level in 0..WIDTH shown as an LSB-aligned
// run of ones, stepped in fill-wrap, fill-saturate, bounce or drain-wrap mode.
module thermo_seq #(
    parameter  int WIDTH = 8,
    localparam int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk_trl,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [LW-1:0]    load_level,
    output logic [WIDTH-1:0] state,
    output logic [LW-1:0]    level,
    output logic             wrap,
    output logic             full,
    output logic             empty
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [1:0]    MODE_FILL_WRAP = 2'b00;
    localparam logic [1:0]    MODE_FILL_SAT  = 2'b01;
    localparam logic [1:0]    MODE_BOUNCE    = 2'b10;
    localparam logic [1:0]    MODE_DRAIN     = 2'b11;
    localparam logic [LW-1:0] MAX_LEVEL      = LW'(WIDTH);

    dir_t             dir;
    dir_t             nxt_dir;
    logic [LW-1:0]    nxt_level;
    logic             nxt_wrap;
    logic [WIDTH-1:0] nxt_state;

    always_ff @(posedge clk_trl or negedge reset) begin
        if (!reset) begin
            level <= '0;
            state <= '0;
            dir   <= DIR_UP;
            wrap  <= 1'b0;
        end else begin
            level <= nxt_level;
            state <= nxt_state;
            dir   <= nxt_dir;
            wrap  <= nxt_wrap;
        end
    end

    // Direction only matters in bounce; every other mode parks it at up so
    // entering bounce starts climbing (or turns at once from the top).
    always_comb begin
        nxt_level = level;
        nxt_dir   = (mode == MODE_BOUNCE) ? dir : DIR_UP;
        nxt_wrap  = 1'b0;
        if (load) begin
            nxt_level = (load_level > MAX_LEVEL) ? MAX_LEVEL : load_level;
            nxt_dir   = ((nxt_level == MAX_LEVEL) && (mode == MODE_BOUNCE)) ? DIR_DOWN : DIR_UP;
        end else if (en) begin
            case (mode)
                MODE_FILL_WRAP: begin
                    if (level < MAX_LEVEL) begin
                        nxt_level = level + LW'(1);
                    end else begin
                        nxt_level = '0;
                        nxt_wrap  = 1'b1;
                    end
                end
                MODE_FILL_SAT: begin
                    if (level < MAX_LEVEL) begin
                        nxt_level = level + LW'(1);
                    end
                end
                MODE_BOUNCE: begin
                    if (dir == DIR_UP) begin
                        if (level < MAX_LEVEL) begin
                            nxt_level = level + LW'(1);
                        end else begin
                            nxt_level = MAX_LEVEL - LW'(1);
                            nxt_dir   = DIR_DOWN;
                            nxt_wrap  = 1'b1;
                        end
                    end else begin
                        if (level > '0) begin
                            nxt_level = level - LW'(1);
                        end else begin
                            nxt_level = LW'(1);
                            nxt_dir   = DIR_UP;
                            nxt_wrap  = 1'b1;
                        end
                    end
                end
                MODE_DRAIN: begin
                    if (level > '0) begin
                        nxt_level = level - LW'(1);
                    end else begin
                        nxt_level = MAX_LEVEL;
                        nxt_wrap  = 1'b1;
                    end
                end
                default: begin
                    nxt_level = level;
                end
            endcase
        end
    end

    // Built bit by bit so level == WIDTH cannot overflow a shift.
    always_comb begin
        nxt_state = '0;
        for (int i = 0; i < WIDTH; i++) begin
            nxt_state[i] = (LW'(i) < nxt_level);
        end
    end

    always_comb begin
        full  = (level == MAX_LEVEL);
        empty = (level == '0);
    end

endmodule

// File: doc/thermo_seq.md
# thermo_seq

Parametrised thermometer-code step sequencer: a level register in 0..WIDTH, presented as a WIDTH-bit thermometer word (level ones, LSB-aligned). It steps by one position per enabled clock in one of four modes: fill-wrap, fill-saturate, bounce and drain-wrap. It also supports synchronous preset, full/empty flags and a wrap/turn pulse. It drives bar-graph progress indicators and sub-period phase markers in the calendar datapath.

## Interface
- WIDTH, 8, thermometer width; legal range 2..32; the sequencer has WIDTH+1 levels.
- LW, $clog2(WIDTH+1), derived level width; not overridden.
- clk_trl  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  step enable, sampled on clk_trl.
- mode  in  2  00 fill-wrap, 01 fill-saturate, 10 bounce, 11 drain-wrap.
- load  in  1  synchronous preset; priority over en.
- load_level  in  LW  preset level; values > WIDTH clamp to WIDTH.
- state  out  WIDTH  thermometer word, registered: state = (1<<level)-1.
- level  out  LW  current level, registered.
- wrap  out  1  registered one-cycle pulse on wrap or turn-around.
- full  out  1  level == WIDTH (decode of level register).
- empty  out  1  level == 0 (decode of level register).

## Operation
- Internal registers: level, state, dir (0 = up, 1 = down), wrap.
- Reset (reset = 0, asynchronous): level = 0, state = 0, dir = up, wrap = 0, so full = 0 and empty = 1. Outputs hold while reset is low.
- Per-edge priority: load, then en, then hold.
- load = 1: level = min(load_level, WIDTH) and wrap = 0.
  - dir = down if the loaded level == WIDTH, else up.
  - en is ignored that cycle.
- en = 1, mode 00 (fill-wrap):
  - level < WIDTH: level + 1.
  - level == WIDTH: level = 0, wrap = 1.
- en = 1, mode 01 (fill-saturate):
  - level < WIDTH: level + 1.
  - level == WIDTH: hold; wrap stays 0.
- en = 1, mode 10 (bounce):
  - Up and level < WIDTH: level + 1.
  - Up and level == WIDTH: level = WIDTH-1, dir = down, wrap = 1.
  - Down and level > 0: level - 1.
  - Down and level == 0: level = 1, dir = up, wrap = 1.
- en = 1, mode 11 (drain-wrap):
  - level > 0: level - 1.
  - level == 0: level = WIDTH, wrap = 1.
- en = 0 and load = 0: level, state and dir hold; wrap = 0.
- dir is used only in mode 10.
  - Any edge with mode != 10 forces dir = up.
  - Entering mode 10 therefore always starts upward, except when level == WIDTH: the next step turns down with wrap = 1.
- Mode changes mid-sequence take effect on the next enabled edge. Level is retained and no reset of the sequence occurs.
- state is written on the same edge as level, from the next-level value. It is never a combinational function of inputs.
- Thermometer invariant: state is always of the form 0..01..1. No other pattern is ever output.

## Timing
- Latency from en/load sampled on edge N to new state/level: visible after edge N (1 cycle).
- wrap is high for exactly the cycle following the wrapping edge. Back-to-back wraps are possible, e.g. WIDTH=2 in bounce mode gives wrap every 2 steps.
- full and empty change in the same cycle as level.
- Reset assertion clears outputs without a clock edge.
- Reset release is synchronous in effect: the first step occurs on the first rising edge with reset high and en = 1.
- Reset mid-sequence discards level and dir entirely.
- No combinational path from any input to any output.

## Test plan
- Async reset: WIDTH=8, run to level 5 (state = 0x1F), drop reset between edges -> state = 0x00, level = 0, empty = 1, wrap = 0 immediately, with no clock edge.
- Fill-wrap: WIDTH=8, mode 00, en = 1 for 10 edges -> state 01,03,07,0F,1F,3F,7F,FF,00,01. full = 1 only at FF. wrap = 1 only in the cycle showing 00.
- Saturate plus hold: WIDTH=8, mode 01, 12 enabled edges -> state sticks at FF, full = 1, wrap never 1. Toggle en = 0 mid-run -> the level freezes for those cycles.
- Bounce: WIDTH=4, mode 10, from reset, 10 edges -> levels 1,2,3,4,3,2,1,0,1,2. wrap = 1 in the cycles showing level 3 (after the 4) and level 1 (after the 0).
- Load: WIDTH=8, load_level = 12 with en = 1 simultaneously -> level = 8, state = FF, wrap = 0 (clamp, and load wins). Then mode 10, en -> level 7, wrap = 1.
- Drain-wrap plus mode switch: WIDTH=8, mode 11 from level 0 -> level 8 (FF) with wrap = 1, then 7F, 3F. Switch to mode 00 at level 6 -> next edge gives level 7 (7F).
